// File: rtl/daisy_chain_arbiter_if.sv
// Request/grant bundle for one daisy_chain_arbiter stage.
// master: request source side; slave: the arbiter itself.
interface daisy_chain_arbiter_if #(
    parameter int unsigned N = 8
);
    logic [N-1:0] req;
    logic         chain_in;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         chain_out;

    modport master (
        output req,
        output chain_in,
        input  gnt,
        input  gnt_valid,
        input  chain_out
    );

    modport slave (
        input  req,
        input  chain_in,
        output gnt,
        output gnt_valid,
        output chain_out
    );
endinterface

// File: rtl/daisy_chain_arbiter.sv
// Fixed-priority daisy-chain arbiter, N request lines, req[N-1] highest priority.
// Grant is registered (one cycle latency); chain_out is combinational so
// cascaded stages resolve in the same cycle.
// Optional macro ARB_LOCK_EN: a granted line keeps its grant while it stays
// requested and chain_in stays high; the release edge yields an empty grant.
module daisy_chain_arbiter #(
    parameter int unsigned N = 8
) (
    input logic                  clk,
    input logic                  rst,
    daisy_chain_arbiter_if.slave bus
);

    logic [N-1:0] next_gnt;
    logic         chain_free;
    logic [N-1:0] gnt_d, gnt_q;
    logic         gnt_valid_q;

    // Ripple the priority enable from the top bit downwards.
    always_comb begin
        logic en;
        en       = bus.chain_in;
        next_gnt = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            next_gnt[i] = bus.req[i] & en;
            en          = en & ~bus.req[i];
        end
        chain_free = en;
    end

`ifdef ARB_LOCK_EN
    // Hold an existing grant while its request and chain_in persist.
    always_comb begin
        gnt_d = next_gnt;
        if (gnt_valid_q) begin
            gnt_d = (bus.chain_in && (|(bus.req & gnt_q))) ? gnt_q : '0;
        end
    end

    // A held lock also starves downstream stages.
    assign bus.chain_out = chain_free & ~gnt_valid_q;
`else
    // Pure fixed priority, re-evaluated every cycle.
    always_comb begin
        gnt_d = next_gnt;
    end

    assign bus.chain_out = chain_free;
`endif

    // Grant register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            gnt_valid_q <= |gnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_daisy_chain_arbiter.sv
// Self-checking bench: one N=8 arbiter against an arithmetic reference model,
// plus two cascaded N=4 stages that must behave like one N=8 stage.
module tb_daisy_chain_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cin;
    logic [7:0] req8;
    logic [7:0] m_gnt;
    logic [7:0] prev_req;
    int         checks = 0;
    int         errors = 0;

`ifdef ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    always #5 clk = ~clk;

    daisy_chain_arbiter_if #(.N(8)) bus8 ();
    daisy_chain_arbiter_if #(.N(4)) hi4 ();
    daisy_chain_arbiter_if #(.N(4)) lo4 ();

    assign bus8.req      = req8;
    assign bus8.chain_in = cin;
    assign hi4.req       = req8[7:4];
    assign hi4.chain_in  = cin;
    assign lo4.req       = req8[3:0];
    assign lo4.chain_in  = hi4.chain_out;

    daisy_chain_arbiter #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    daisy_chain_arbiter #(.N(4)) u_hi (
        .clk (clk),
        .rst (rst),
        .bus (hi4)
    );

    daisy_chain_arbiter #(.N(4)) u_lo (
        .clk (clk),
        .rst (rst),
        .bus (lo4)
    );

    // Highest set bit via its logarithm: 2^floor(log2(r)).
    function automatic logic [7:0] arb(input logic [7:0] r, input logic c);
        int unsigned v;
        v = r;
        if (!c || v == 0) return 8'h00;
        return 8'(1 << ($clog2(v + 1) - 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check the
    // combinational chain_out, advance the model across the rising edge, then
    // compare the registered outputs on the following falling edge.
    task automatic apply(input logic r_rst, input logic [7:0] r, input logic c);
        logic exp_co;
        rst  = r_rst;
        req8 = r;
        cin  = c;
        #1;
        exp_co = c && (r == 8'h00) && !(LockEn && m_gnt != 8'h00);
        chk("chain_out", bus8.chain_out, exp_co);
        prev_req = r;
        if (r_rst) begin
            m_gnt = 8'h00;
        end else if (LockEn && m_gnt != 8'h00) begin
            m_gnt = (c && (r & m_gnt) != 8'h00) ? m_gnt : 8'h00;
        end else begin
            m_gnt = arb(r, c);
        end
        @(posedge clk);
        @(negedge clk);
        chk("gnt_model", bus8.gnt, m_gnt);
        chk("gnt_valid_model", bus8.gnt_valid, m_gnt != 8'h00);
    endtask

    // Idle cycle first so directed values hold in both builds.
    task automatic directed(input string tag, input logic [7:0] r, input logic [7:0] exp);
        apply(1'b0, 8'h00, 1'b1);
        apply(1'b0, r, 1'b1);
        chk(tag, bus8.gnt, exp);
    endtask

    initial begin
        m_gnt    = 8'h00;
        prev_req = 8'h00;
        rst      = 1'b1;
        req8     = 8'hFF;
        cin      = 1'b1;
        @(negedge clk);

        // Reset dominance and first grant after release.
        apply(1'b1, 8'hFF, 1'b1);
        apply(1'b1, 8'hFF, 1'b1);
        chk("rst_gnt", bus8.gnt, 8'h00);
        chk("rst_valid", bus8.gnt_valid, 1'b0);
        apply(1'b0, 8'hFF, 1'b1);
        chk("rel_gnt", bus8.gnt, 8'h80);
        chk("rel_valid", bus8.gnt_valid, 1'b1);

        // Single requests and priority resolution.
        directed("single_01", 8'h01, 8'h01);
        directed("single_10", 8'h10, 8'h10);
        directed("prio_05", 8'h05, 8'h04);
        directed("prio_3c", 8'h3C, 8'h20);
        directed("prio_80", 8'h80, 8'h80);

        // Chain behaviour.
        apply(1'b0, 8'h00, 1'b1);
        chk("chain_idle_gnt", bus8.gnt, 8'h00);
        req8 = 8'h00;
        #1;
        chk("chain_idle_out", bus8.chain_out, 1'b1);
        req8 = 8'h02;
        #1;
        chk("chain_busy_out", bus8.chain_out, 1'b0);
        apply(1'b0, 8'hFF, 1'b0);
        chk("chain_off_gnt", bus8.gnt, 8'h00);
        chk("chain_off_out", bus8.chain_out, 1'b0);

`ifndef ARB_LOCK_EN
        // Exhaustive sweep with invariants and cascade equivalence.
        for (int v = 0; v < 256; v++) begin
            logic [7:0] g;
            apply(1'b0, 8'(v), 1'b1);
            g = bus8.gnt;
            chk("cascade_gnt", {hi4.gnt, lo4.gnt}, arb(8'(v), 1'b1));
            chk("cascade_valid", hi4.gnt_valid | lo4.gnt_valid, v != 0);
            if (v != 0) begin
                chk("sweep_onehot", $onehot(g), 1'b1);
                chk("sweep_lo", int'(g) <= int'(prev_req), 1'b1);
                chk("sweep_hi", int'(prev_req) < 2 * int'(g), 1'b1);
            end
        end
        req8 = 8'h00;
        #1;
        chk("cascade_chain_out", lo4.chain_out, 1'b1);
        req8 = 8'h01;
        #1;
        chk("cascade_chain_busy", lo4.chain_out, 1'b0);
        @(negedge clk);
`else
        // Lock holds against a higher-priority arrival.
        directed("lock_grant", 8'h01, 8'h01);
        apply(1'b0, 8'h81, 1'b1);
        chk("lock_hold", bus8.gnt, 8'h01);
        apply(1'b0, 8'h80, 1'b1);
        chk("lock_release", bus8.gnt, 8'h00);
        apply(1'b0, 8'h80, 1'b1);
        chk("lock_rearb", bus8.gnt, 8'h80);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            logic       c;
            logic       rr;
            r  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            c  = ($urandom_range(0, 7) != 0);
            rr = ($urandom_range(0, 31) == 0);
            apply(rr, r, c);
            chk("no_x", $isunknown(bus8.gnt), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/daisy_chain_arbiter.md
Name: daisy_chain_arbiter

Overview:
- Parameterizable N-request fixed-priority daisy-chain arbiter.
- Grants exactly one requester: the highest-priority active request, where the most-significant bit has the highest priority.
- Expandable: chain_in/chain_out let several instances cascade into a wider arbiter, with upstream instances having higher priority.
- The grant is registered, so it sits in a synchronous control path between request sources and a shared resource.

Parameters:
- N, 8, number of request/grant lines; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector; req[N-1] is highest priority, req[0] lowest.
- chain_in  input  1  priority enable from upstream stage. Tie to 1 on the top (highest-priority) stage.
- gnt  output  N  registered one-hot (or zero) grant vector.
- gnt_valid  output  1  registered; equals OR-reduction of gnt.
- chain_out  output  1  combinational enable to the downstream stage.

Behaviour:
- Combinational next-grant next_gnt:
  - If chain_in=0: next_gnt=0.
  - Else: next_gnt is the one-hot vector of the most-significant set bit of req.
  - If req=0: next_gnt=0.
- Numeric invariant whenever next_gnt≠0: next_gnt ≤ req < 2·next_gnt (unsigned).
- next_gnt is never multi-hot, and a bit is never set in next_gnt unless the matching req bit is set.
- Registered outputs:
  - On rising clk with rst=1: gnt←0, gnt_valid←0.
  - Otherwise: gnt←next_gnt, gnt_valid←|next_gnt.
  - Latency: exactly one cycle from req/chain_in change to gnt change.
- chain_out = chain_in & ~|req. It is purely combinational, with no register in the chain path, so cascaded stages resolve in the same cycle.
- Reset dominance:
  - Reset asserted mid-operation clears gnt on that edge regardless of req.
  - First valid grant appears on the first edge after rst deasserts.
- Request withdrawn: a withdrawn request loses its grant on the next edge. A higher-priority request arriving preempts a lower one on the next edge (no lock, unless the optional feature is enabled).
- Width rules: N=1 degenerates to gnt←req & chain_in.
- No X propagation: with req fully known, gnt must be fully known.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Once bit k is granted, gnt keeps bit k on subsequent edges while req[k]=1 and chain_in=1, even if higher-priority bits assert.
  - Grant is released on the edge after req[k] drops or chain_in drops. Arbitration then resumes from the highest-priority request.
  - While a lock is held, chain_out=0.
  - Reset clears the lock.
- Undefined: pure fixed-priority behaviour as specified above, re-evaluated every cycle.

Test Plan:
- Reset: rst=1 for 2 cycles with req=8'hFF → gnt=8'h00, gnt_valid=0. Release rst → next edge gnt=8'h80, gnt_valid=1.
- Single requests: req=8'h01 → gnt=8'h01. req=8'h10 → gnt=8'h10. Each updates one cycle after req changes.
- Priority resolution: req=8'h05 → gnt=8'h04. req=8'h3C → gnt=8'h20. req=8'h80 → gnt=8'h80.
- Exhaustive sweep, N=8, chain_in=1: req 1..255, one value per cycle. Each cycle check gnt is one-hot, gnt ≤ req < 2·gnt (value from previous cycle's req), and no errors through req=8'hFF.
- Chain: req=0, chain_in=1 → chain_out=1, gnt=0. req=8'h02 → chain_out=0. chain_in=0 with req=8'hFF → gnt=0 next edge, chain_out=0. Two cascaded N=4 stages must match one N=8 stage for all 256 patterns.
- ARB_LOCK_EN build: req=8'h01 granted, then req=8'h81 → gnt stays 8'h01. Drop req[0] (req=8'h80) → gnt=8'h00 on the next edge, then 8'h80 on the following edge.
